// File: rtl/adder_entry_ctrl_pkg.sv
// adder_entry_ctrl_pkg: shared state encoding and operand width
package adder_entry_ctrl_pkg;
  localparam int OP_W = 4;
  typedef enum logic [1:0] {
    ST_ENTER_A = 2'b01,
    ST_ENTER_B = 2'b10,
    ST_SHOW    = 2'b11
  } state_t;
endpackage

// File: rtl/adder_entry_ctrl_if.sv
// adder_entry_ctrl_if: board-side switches/keys/LEDs and adder operand bus
interface adder_entry_ctrl_if;
  import adder_entry_ctrl_pkg::*;
  logic [OP_W-1:0] sw;
  logic            key_next;
  logic            key_clear;
  logic            ovf_in;
  logic [OP_W-1:0] op_a;
  logic [OP_W-1:0] op_b;
  logic            disp_en;
  logic [1:0]      stage;
  logic            ovf_led;
  logic [7:0]      op_count;
  modport master (output sw, key_next, key_clear, ovf_in,
                  input op_a, op_b, disp_en, stage, ovf_led, op_count);
  modport slave  (input sw, key_next, key_clear, ovf_in,
                  output op_a, op_b, disp_en, stage, ovf_led, op_count);
endinterface

// File: rtl/adder_entry_ctrl_key_debounce.sv
// key_debounce: 2-flop synchroniser, debouncer and one-cycle rising-edge press pulse
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_key,
  output logic o_press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt;
  logic          r_arm, r_level, r_level_d, r_press;
  logic          w_key;
  assign w_key = r_sync[1];
  // Until the key is seen stably low after reset, a held key must not fire a press
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync    <= '0;
      r_cnt     <= '0;
      r_arm     <= 1'b0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
      r_press   <= 1'b0;
    end else begin
      r_sync    <= {r_sync[0], i_key};
      r_level_d <= r_level;
      r_press   <= r_level & ~r_level_d;
      if (!r_arm) begin
        r_cnt <= (w_key || r_cnt == LAST) ? '0 : r_cnt + 1'b1;
        r_arm <= !w_key && r_cnt == LAST;
      end else if (w_key == r_level) r_cnt <= '0;
      else if (r_cnt == LAST) begin
        r_level <= w_key;
        r_cnt   <= '0;
      end else r_cnt <= r_cnt + 1'b1;
    end
  end
  assign o_press = r_press;
endmodule

// File: rtl/adder_entry_ctrl.sv
// adder_entry_ctrl: operand entry FSM, display gating, overflow blink and addition counter
module adder_entry_ctrl
  import adder_entry_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int BLINK_DIV       = 12500000
) (
  input logic               clk,
  input logic               reset,
  adder_entry_ctrl_if.slave bus
);
  localparam int BW = $clog2(BLINK_DIV + 1);
  localparam logic [BW-1:0] BLAST = BW'(BLINK_DIV - 1);
  state_t          r_state, w_nxt;
  logic [OP_W-1:0] r_op_a, r_op_b;
  logic            r_disp, r_ovf_led, r_phase;
  logic [BW-1:0]   r_blink_cnt;
  logic [7:0]      r_op_count;
  logic            w_next, w_clr;
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next (
    .clk(clk), .reset(reset), .i_key(bus.key_next), .o_press(w_next));
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
    .clk(clk), .reset(reset), .i_key(bus.key_clear), .o_press(w_clr));
  always_comb
    w_nxt = w_clr ? ST_ENTER_A : !w_next ? r_state :
            r_state == ST_ENTER_A ? ST_ENTER_B :
            r_state == ST_ENTER_B ? ST_SHOW : ST_ENTER_A;
  // Outputs follow the next state so disp_en/ovf_led change on the same edge as stage
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_ENTER_A;
      r_op_a      <= '0;
      r_op_b      <= '0;
      r_disp      <= 1'b0;
      r_ovf_led   <= 1'b0;
      r_phase     <= 1'b0;
      r_blink_cnt <= '0;
      r_op_count  <= '0;
    end else begin
      r_state   <= w_nxt;
      r_disp    <= w_nxt == ST_SHOW;
      r_ovf_led <= w_nxt == ST_SHOW && r_state == ST_SHOW && bus.ovf_in && r_phase;
      if (w_clr) begin
        r_op_a <= '0;
        r_op_b <= '0;
      end else begin
        if (r_state == ST_ENTER_A) r_op_a <= bus.sw;
        if (r_state == ST_ENTER_B) r_op_b <= bus.sw;
        if (r_state == ST_ENTER_B && w_next) r_op_count <= r_op_count + 1'b1;
      end
      if (w_nxt == ST_SHOW && r_state != ST_SHOW) begin
        r_phase     <= 1'b1;
        r_blink_cnt <= '0;
      end else if (w_nxt == ST_SHOW) begin
        r_blink_cnt <= r_blink_cnt == BLAST ? '0 : r_blink_cnt + 1'b1;
        if (r_blink_cnt == BLAST) r_phase <= ~r_phase;
      end else r_blink_cnt <= '0;
    end
  end
  assign bus.op_a     = r_op_a;
  assign bus.op_b     = r_op_b;
  assign bus.disp_en  = r_disp;
  assign bus.stage    = r_state;
  assign bus.ovf_led  = r_ovf_led;
  assign bus.op_count = r_op_count;
endmodule
